reset_sequencer: RTL and testbench

- Power-on/soft reset sequencer for the fabric, driven by the system reset and the PLL lock.
- Holds all downstream reset domains in reset until the PLL lock is stable for a set time, then releases them one at a time in fixed order.
- Re-asserts every domain immediately when the PLL loses lock.
- Its outputs feed the per-domain reset synchronizers.

---
 rtl/reset_sequencer.sv | 160 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Fabric reset sequencer: qualifies PLL lock, then releases reset domains in index order.
// Optional soft reset re-entry via soft_reset_req when RST_SEQ_SOFT_RESET_EN is defined.
module reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int LOCK_FILTER = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pll_lock,
    input  logic                  soft_reset_req,
    output logic [NUM_STAGES-1:0] stage_reset_n,
    output logic                  seq_done,
    output logic                  lock_lost
);

    localparam int LCW = $clog2(LOCK_FILTER + 1);
    localparam int HCW = $clog2(HOLD_CYCLES + 1);
    localparam int GCW = $clog2(STAGE_GAP + 1);
    localparam int SIW = $clog2(NUM_STAGES + 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD,
        RELEASE,
        DONE
    } state_t;

    state_t                state, state_nxt;
    logic                  lock_meta, lock_s;
    logic [LCW-1:0]        lock_cnt, lock_cnt_nxt;
    logic [HCW-1:0]        hold_cnt, hold_cnt_nxt;
    logic [GCW-1:0]        gap_cnt, gap_cnt_nxt;
    logic [SIW-1:0]        stage_idx, stage_idx_nxt;
    logic [NUM_STAGES-1:0] stage_reset_n_nxt;
    logic                  seq_done_nxt, lock_lost_nxt;
    logic                  soft_req;

`ifdef RST_SEQ_SOFT_RESET_EN
    assign soft_req = soft_reset_req;
`else
    logic unused_soft_reset_req;
    assign soft_req              = 1'b0;
    assign unused_soft_reset_req = soft_reset_req;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= WAIT_LOCK;
            lock_cnt      <= '0;
            hold_cnt      <= '0;
            gap_cnt       <= '0;
            stage_idx     <= '0;
            stage_reset_n <= '0;
            seq_done      <= 1'b0;
            lock_lost     <= 1'b0;
        end else begin
            state         <= state_nxt;
            lock_cnt      <= lock_cnt_nxt;
            hold_cnt      <= hold_cnt_nxt;
            gap_cnt       <= gap_cnt_nxt;
            stage_idx     <= stage_idx_nxt;
            stage_reset_n <= stage_reset_n_nxt;
            seq_done      <= seq_done_nxt;
            lock_lost     <= lock_lost_nxt;
        end
    end

    // NOTE: every next-value is defaulted to its current value first, so no path infers a latch.
    always_comb begin
        state_nxt         = state;
        lock_cnt_nxt      = lock_cnt;
        hold_cnt_nxt      = hold_cnt;
        gap_cnt_nxt       = gap_cnt;
        stage_idx_nxt     = stage_idx;
        stage_reset_n_nxt = stage_reset_n;
        seq_done_nxt      = seq_done;
        lock_lost_nxt     = lock_lost;

        case (state)
            WAIT_LOCK: begin
                if (!lock_s) begin
                    lock_cnt_nxt = '0;
                end else if (lock_cnt == LCW'(LOCK_FILTER - 1)) begin
                    lock_cnt_nxt = LCW'(LOCK_FILTER);
                    hold_cnt_nxt = '0;
                    state_nxt    = HOLD;
                end else begin
                    lock_cnt_nxt = lock_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (hold_cnt == HCW'(HOLD_CYCLES - 1)) begin
                    hold_cnt_nxt      = HCW'(HOLD_CYCLES);
                    stage_reset_n_nxt = (stage_reset_n << 1) | NUM_STAGES'(1);
                    if (NUM_STAGES == 1) begin
                        seq_done_nxt = 1'b1;
                        state_nxt    = DONE;
                    end else begin
                        stage_idx_nxt = SIW'(1);
                        gap_cnt_nxt   = '0;
                        state_nxt     = RELEASE;
                    end
                end else begin
                    hold_cnt_nxt = hold_cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (gap_cnt == GCW'(STAGE_GAP - 1)) begin
                    // Releases are strictly in order, so the mask fills from bit 0 upward.
                    stage_reset_n_nxt = (stage_reset_n << 1) | NUM_STAGES'(1);
                    gap_cnt_nxt       = '0;
                    if (stage_idx == SIW'(NUM_STAGES - 1)) begin
                        seq_done_nxt = 1'b1;
                        state_nxt    = DONE;
                    end else begin
                        stage_idx_nxt = stage_idx + 1'b1;
                    end
                end else begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                end
            end
            default: ;
        endcase

        // Lock loss outranks everything, including a simultaneous soft request.
        if (state != WAIT_LOCK) begin
            if (!lock_s) begin
                state_nxt         = WAIT_LOCK;
                lock_cnt_nxt      = '0;
                hold_cnt_nxt      = '0;
                gap_cnt_nxt       = '0;
                stage_idx_nxt     = '0;
                stage_reset_n_nxt = '0;
                seq_done_nxt      = 1'b0;
                if (state == DONE) lock_lost_nxt = 1'b1;
            end else if (soft_req) begin
                state_nxt         = HOLD;
                hold_cnt_nxt      = '0;
                gap_cnt_nxt       = '0;
                stage_idx_nxt     = '0;
                stage_reset_n_nxt = '0;
                seq_done_nxt      = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues expected output changes,
// a negedge monitor pops one entry per observed change and checks value and cycle.
module tb_reset_sequencer;

    localparam int NS  = 4;
    localparam int LF  = 4;
    localparam int HC  = 16;
    localparam int GAP = 8;

    logic          clock;
    logic          reset;
    logic          pll_lock;
    logic          soft_reset_req;
    logic [NS-1:0] stage_reset_n;
    logic          seq_done;
    logic          lock_lost;

    reset_sequencer #(
        .NUM_STAGES (NS),
        .LOCK_FILTER(LF),
        .HOLD_CYCLES(HC),
        .STAGE_GAP  (GAP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pll_lock      (pll_lock),
        .soft_reset_req(soft_reset_req),
        .stage_reset_n (stage_reset_n),
        .seq_done      (seq_done),
        .lock_lost     (lock_lost)
    );

    typedef struct {
        string         tag;
        int            cyc;
        logic [NS-1:0] srn;
        logic          done;
        logic          lost;
    } exp_t;

    exp_t         exp_q[$];
    int           cyc;
    int           n_checks;
    int           n_pass;
    logic [NS+1:0] prev;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic push(input string tag, input int c, input logic [NS-1:0] srn,
                        input logic done, input logic lost);
        exp_t e;
        e.tag  = tag;
        e.cyc  = c;
        e.srn  = srn;
        e.done = done;
        e.lost = lost;
        exp_q.push_back(e);
    endtask

    // t0 is the edge at which stage 0 is expected to release.
    task automatic push_seq(input string tag, input int t0, input int nst, input logic lost);
        logic [NS-1:0] m;
        m = '0;
        for (int i = 0; i < nst; i++) begin
            m = (m << 1) | NS'(1);
            push($sformatf("%s_s%0d", tag, i), t0 + i * GAP, m, (i == NS - 1), lost);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    // Monitor: any change of the output triple consumes one scoreboard entry.
    always @(negedge clock) begin
        logic [NS+1:0] cur;
        exp_t e;
        cur = {stage_reset_n, seq_done, lock_lost};
        if (cur !== prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_change", 64'(cur), 64'(prev));
            end else begin
                e = exp_q.pop_front();
                check({e.tag, "_value"}, 64'(cur), 64'({e.srn, e.done, e.lost}));
                check({e.tag, "_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
        prev = cur;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int c;
        cyc            = 0;
        n_checks       = 0;
        n_pass         = 0;
        prev           = '0;
        reset          = 1'b1;
        pll_lock       = 1'b0;
        soft_reset_req = 1'b0;

        repeat (3) @(negedge clock);
        check("reset_stage_reset_n", 64'(stage_reset_n), 64'd0);
        check("reset_seq_done", 64'(seq_done), 64'd0);
        check("reset_lock_lost", 64'(lock_lost), 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // Three-cycle glitch must only restart qualification.
        pll_lock = 1'b1;
        repeat (3) @(negedge clock);
        pll_lock = 1'b0;
        repeat (10) @(negedge clock);
        check("glitch_no_release", 64'(stage_reset_n), 64'd0);

        // Stable lock from edge m; drop at m+33 while in RELEASE.
        pll_lock = 1'b1;
        k = cyc + 1;
        push_seq("glitch_relock", k + 21, 2, 1'b0);
        while (cyc < k + 33) @(negedge clock);
        c = cyc;
        push("mid_release_loss", c + 3, '0, 1'b0, 1'b0);
        pll_lock = 1'b0;
        drain(20);
        repeat (5) @(negedge clock);

        // Clean full sequence: 0001@k+21, 0011@k+29, 0111@k+37, 1111+done@k+45.
        pll_lock = 1'b1;
        k = cyc + 1;
        push_seq("full", k + 21, NS, 1'b0);
        drain(80);
        repeat (4) @(negedge clock);

        // Lock loss in DONE sets sticky lock_lost.
        c = cyc;
        push("done_loss", c + 3, '0, 1'b0, 1'b1);
        pll_lock = 1'b0;
        drain(20);
        repeat (5) @(negedge clock);
        pll_lock = 1'b1;
        k = cyc + 1;
        push_seq("relock_sticky", k + 21, NS, 1'b1);
        drain(80);
        repeat (4) @(negedge clock);

        // Reset pulse clears lock_lost and restarts from qualification.
        c = cyc;
        push("reset_clear", c + 1, '0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        @(negedge clock);
        #2 reset = 1'b0;
        k = c + 2;
        push_seq("after_reset", k + 21, 3, 1'b0);
        while (cyc < k + 40) @(negedge clock);
        c = cyc;
        push("mid_reset", c + 1, '0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        @(negedge clock);
        #2 reset = 1'b0;
        k = c + 2;
        push_seq("reset_repeat", k + 21, NS, 1'b0);
        drain(80);
        repeat (4) @(negedge clock);

`ifdef RST_SEQ_SOFT_RESET_EN
        // Soft request sampled at edge c+1: HOLD restarts without lock qualification.
        c = cyc;
        soft_reset_req = 1'b1;
        push("soft_clear", c + 1, '0, 1'b0, 1'b0);
        push_seq("soft_seq", c + 1 + HC, NS, 1'b0);
        @(negedge clock);
        soft_reset_req = 1'b0;
        drain(80);
        repeat (4) @(negedge clock);

        // Soft request coinciding with lock_s low: lock loss wins.
        c = cyc;
        pll_lock = 1'b0;
        repeat (2) @(negedge clock);
        soft_reset_req = 1'b1;
        push("soft_vs_loss", c + 3, '0, 1'b0, 1'b1);
        @(negedge clock);
        soft_reset_req = 1'b0;
        drain(20);
        repeat (5) @(negedge clock);
        pll_lock = 1'b1;
        k = cyc + 1;
        push_seq("soft_vs_loss_relock", k + 21, NS, 1'b1);
        drain(80);
`else
        // Without the feature the request must be ignored.
        soft_reset_req = 1'b1;
        @(negedge clock);
        soft_reset_req = 1'b0;
        repeat (20) @(negedge clock);
        check("soft_ignored_srn", 64'(stage_reset_n), 64'(NS'('1)));
        check("soft_ignored_done", 64'(seq_done), 64'd1);
`endif

        repeat (5) @(negedge clock);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
